conv_mac_stage: RTL and testbench

CONV_MAC_STAGE -- requirements
Module: conv_mac_stage

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv_mac_stage_if.sv | 27 ++
 rtl/conv_mac_stage_pix_mult.sv | 19 +
 rtl/conv_mac_stage.sv | 119 +++++++++++
 tb/tb_conv_mac_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizing constants and FSM state type for the conv MAC stage
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int TAPS   = 9;
    localparam int ACC_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/conv_mac_stage_if.sv
// rtl/conv_mac_stage_if.sv - beat input and accumulator write bus of the conv MAC stage
//   in_valid/in_ready : beat handshake
//   pixel/weight      : unsigned pixel, signed weight of the beat
//   tap_idx           : next tap index (weight ROM address)
//   acc_data/acc_w_en : window sum and one-cycle write strobe to the accumulator
interface conv_mac_if #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int ACC_W  = conv_pkg::ACC_W
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pixel;
    logic [DATA_W-1:0] weight;
    logic [3:0]        tap_idx;
    logic [ACC_W-1:0]  acc_data;
    logic              acc_w_en;

    modport master (
        output in_valid, pixel, weight,
        input  in_ready, tap_idx, acc_data, acc_w_en
    );

    modport slave (
        input  in_valid, pixel, weight,
        output in_ready, tap_idx, acc_data, acc_w_en
    );
endinterface

// File: rtl/conv_mac_stage_pix_mult.sv
// rtl/conv_mac_stage_pix_mult.sv - combinational unsigned pixel x signed weight product
//   pixel   : unsigned DATA_W-bit pixel
//   weight  : signed DATA_W-bit weight
//   product : signed (2*DATA_W+1)-bit product
module pix_mult #(
    parameter int DATA_W = conv_pkg::DATA_W
) (
    input  logic [DATA_W-1:0]          pixel,
    input  logic [DATA_W-1:0]          weight,
    output logic signed [2*DATA_W:0]   product
);
    logic signed [DATA_W:0]   pixel_s;
    logic signed [DATA_W-1:0] weight_s;

    // A zero MSB keeps the pixel non-negative inside a signed multiply.
    assign pixel_s  = {1'b0, pixel};
    assign weight_s = weight;
    assign product  = pixel_s * weight_s;
endmodule

// File: rtl/conv_mac_stage.sv
// rtl/conv_mac_stage.sv - TAPS-beat multiply-accumulate window feeding an accumulator write port
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous discard of the partial window
//   bus        : beat handshake, tap index, accumulator write (conv_mac_if.slave)
//   busy       : window in progress or being emitted
//   Build option RELU_EN: negative emitted sums are written as zero.
module conv_mac_stage
    import conv_pkg::*;
#(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int TAPS   = conv_pkg::TAPS,
    parameter int ACC_W  = conv_pkg::ACC_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    conv_mac_if.slave  bus,
    output logic       busy
);
    localparam int PROD_W = 2 * DATA_W + 1;

    state_t             state, state_d;
    logic [ACC_W-1:0]   sum, sum_d;
    logic [3:0]         tap, tap_d;
    logic [ACC_W-1:0]   acc_data, acc_data_d;
    logic signed [PROD_W-1:0] product;
    logic [ACC_W-1:0]   product_ext;
    logic [ACC_W-1:0]   sum_next;
    logic [ACC_W-1:0]   emit_val;
    logic               in_ready;
    logic               accept;
    logic               last_tap;

    pix_mult #(.DATA_W(DATA_W)) u_pix_mult (
        .pixel   (bus.pixel),
        .weight  (bus.weight),
        .product (product)
    );

    // Signed size cast sign-extends the product to the accumulator width.
    assign product_ext = ACC_W'(product);

    assign in_ready = (state != EMIT) && !clear;
    assign accept   = bus.in_valid && in_ready;
    assign last_tap = (tap == 4'(TAPS - 1));

    // First beat of a window starts from zero rather than the stale sum.
    assign sum_next = (state == IDLE) ? product_ext : sum + product_ext;

`ifdef RELU_EN
    assign emit_val = sum_next[ACC_W-1] ? '0 : sum_next;
`else
    assign emit_val = sum_next;
`endif

    always_comb begin
        state_d    = state;
        sum_d      = sum;
        tap_d      = tap;
        acc_data_d = acc_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    sum_d = sum_next;
                    if (TAPS == 1) begin
                        state_d    = EMIT;
                        tap_d      = 4'd0;
                        acc_data_d = emit_val;
                    end else begin
                        state_d = ACCUM;
                        tap_d   = 4'd1;
                    end
                end
            end
            ACCUM: begin
                if (clear) begin
                    state_d = IDLE;
                    tap_d   = 4'd0;
                end else if (accept) begin
                    sum_d = sum_next;
                    if (last_tap) begin
                        state_d    = EMIT;
                        tap_d      = 4'd0;
                        acc_data_d = emit_val;
                    end else begin
                        tap_d = tap + 4'd1;
                    end
                end
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                tap_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sum      <= '0;
            tap      <= 4'd0;
            acc_data <= '0;
        end else begin
            state    <= state_d;
            sum      <= sum_d;
            tap      <= tap_d;
            acc_data <= acc_data_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.tap_idx  = tap;
    assign bus.acc_data = acc_data;
    assign bus.acc_w_en = (state == EMIT);
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_conv_mac_stage.sv
// tb/tb_conv_mac_stage.sv - directed self-checking bench for conv_mac_stage
module tb_conv_mac_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic busy;
    int   total = 0;
    int   bad = 0;
    int   pulse_cnt = 0;

    conv_mac_if #(.DATA_W(8), .ACC_W(32)) bus ();

    conv_mac_stage #(.DATA_W(8), .TAPS(9), .ACC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.acc_w_en === 1'b1) pulse_cnt <= pulse_cnt + 1;

    task automatic run_window(input logic [7:0] p, input logic [7:0] w, input bit gap,
                              input logic [31:0] exp_val, input string name);
        int start;
        start = pulse_cnt;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            total++;
            if (bus.tap_idx !== 4'(i)) begin
                bad++;
                $display("FAIL %s tap_idx beat %0d: got %0d expected %0d", name, i, bus.tap_idx, i);
            end
            bus.in_valid = 1'b1;
            bus.pixel    = p;
            bus.weight   = w;
            if (gap && i < 8) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                total++;
                if (bus.tap_idx !== 4'(i + 1)) begin
                    bad++;
                    $display("FAIL %s tap_idx after beat %0d: got %0d expected %0d", name, i, bus.tap_idx, i + 1);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.acc_w_en !== 1'b1 || bus.acc_data !== exp_val || bus.in_ready !== 1'b0 ||
            bus.tap_idx !== 4'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s emit: w_en=%b data=%h ready=%b tap=%0d busy=%b expected 1 %h 0 0 1",
                     name, bus.acc_w_en, bus.acc_data, bus.in_ready, bus.tap_idx, busy, exp_val);
        end
        @(negedge clk);
        total++;
        if (bus.acc_w_en !== 1'b0 || busy !== 1'b0 || bus.acc_data !== exp_val ||
            pulse_cnt !== start + 1) begin
            bad++;
            $display("FAIL %s after emit: w_en=%b busy=%b data=%h pulses=%0d expected 0 0 %h %0d",
                     name, bus.acc_w_en, busy, bus.acc_data, pulse_cnt - start, exp_val, 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.acc_data !== 32'd0 || bus.acc_w_en !== 1'b0 || busy !== 1'b0 || bus.tap_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset hold: data=%h w_en=%b busy=%b tap=%0d expected 0 0 0 0",
                     bus.acc_data, bus.acc_w_en, busy, bus.tap_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.tap_idx !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset release: ready=%b tap=%0d busy=%b expected 1 0 0",
                     bus.in_ready, bus.tap_idx, busy);
        end
    endtask

    task automatic test_basic();
        run_window(8'd1, 8'd1, 1'b0, 32'h0000_0009, "basic");
    endtask

    task automatic test_negative();
`ifdef RELU_EN
        run_window(8'd255, 8'h80, 1'b0, 32'h0000_0000, "negative");
`else
        run_window(8'd255, 8'h80, 1'b0, 32'hFFFB_8480, "negative");
`endif
    endtask

    task automatic test_gaps();
        run_window(8'd2, 8'd3, 1'b1, 32'h0000_0036, "gaps");
    endtask

    task automatic test_clear();
        int start;
        start = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.pixel    = 8'd7;
            bus.weight   = 8'd5;
        end
        @(negedge clk);
        total++;
        if (bus.tap_idx !== 4'd4 || busy !== 1'b1) begin
            bad++;
            $display("FAIL clear pre: tap=%0d busy=%b expected 4 1", bus.tap_idx, busy);
        end
        clear = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear ready: got %b expected 0", bus.in_ready);
        end
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || bus.tap_idx !== 4'd0 || bus.acc_data !== 32'h0000_0036 ||
            pulse_cnt !== start) begin
            bad++;
            $display("FAIL clear post: busy=%b tap=%0d data=%h pulses=%0d expected 0 0 00000036 0",
                     busy, bus.tap_idx, bus.acc_data, pulse_cnt - start);
        end
        run_window(8'd2, 8'd3, 1'b0, 32'h0000_0036, "after clear");
    endtask

    task automatic test_reset_mid();
        int start;
        start = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.pixel    = 8'd4;
            bus.weight   = 8'd4;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || bus.tap_idx !== 4'd0 || bus.acc_data !== 32'd0 || bus.acc_w_en !== 1'b0) begin
            bad++;
            $display("FAIL reset mid async: busy=%b tap=%0d data=%h w_en=%b expected 0 0 0 0",
                     busy, bus.tap_idx, bus.acc_data, bus.acc_w_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (pulse_cnt !== start || bus.acc_data !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset mid after: pulses=%0d data=%h busy=%b expected 0 0 0",
                     pulse_cnt - start, bus.acc_data, busy);
        end
        run_window(8'd1, 8'd1, 1'b0, 32'h0000_0009, "after reset");
    endtask

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.pixel    = '0;
        bus.weight   = '0;
        test_reset();
        test_basic();
        test_negative();
        test_gaps();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
